mips_bus_arb: RTL and testbench

Two-master memory-mapped bus controller for the MIPS system. Master 0 is the CPU data port and master 1 is the DMA engine. The block arbitrates round-robin between the two masters. It decodes the granted address into three regions:
- data RAM: addr[31:8]=24'h000000
- IO port 1: addr[31:8]=24'h000008
- IO port 2: addr[31:8]=24'h000009

It issues one-cycle write strobes, inserts per-region wait states and returns read data or a bus error. It sits between the masters and the RAM/IO slaves.

---
 rtl/mips_bus_pkg.sv | 12 +
 rtl/mips_bus_decode.sv | 16 +
 rtl/mips_bus_arb.sv | 164 ++++++++++++++++
 tb/tb_mips_bus_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and region bases for the MIPS bus
package mips_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef enum logic [1:0] {REG_MEM, REG_IO1, REG_IO2, REG_NONE} region_t;

  localparam logic [23:0] MEM_BASE = 24'h000000;
  localparam logic [23:0] IO1_BASE = 24'h000008;
  localparam logic [23:0] IO2_BASE = 24'h000009;

endpackage

// File: rtl/mips_bus_decode.sv
// rtl/mips_bus_decode.sv - address page (addr[31:8]) to region decoder
module mips_bus_decode
  import mips_bus_pkg::*;
(
  input  logic [23:0] page,
  output region_t     region
);

  always_comb begin
    region = REG_NONE;
    if (page == MEM_BASE)      region = REG_MEM;
    else if (page == IO1_BASE) region = REG_IO1;
    else if (page == IO2_BASE) region = REG_IO2;
  end

endmodule

// File: rtl/mips_bus_arb.sv
// rtl/mips_bus_arb.sv - two-master round-robin bus controller with region decode,
// write strobes, per-region wait states and registered responses
module mips_bus_arb
  import mips_bus_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int IO_WAIT  = 1,
  parameter int WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic        m_err,
  output logic [31:0] m_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        wem,
  output logic        we1,
  output logic        we2,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] io1_rdata,
  input  logic [31:0] io2_rdata
);

  localparam int WAIT_MAX = (1 << WAIT_W) - 1;
  localparam logic [WAIT_W-1:0] MEM_CNT = WAIT_W'((MEM_WAIT > WAIT_MAX) ? WAIT_MAX : MEM_WAIT);
  localparam logic [WAIT_W-1:0] IO_CNT  = WAIT_W'((IO_WAIT > WAIT_MAX) ? WAIT_MAX : IO_WAIT);

  state_t            state, state_nx;
  region_t           region, sel_region;
  logic              last_gnt, gnt, we_q;
  logic [WAIT_W-1:0] cnt;

  logic              any_req, win, sel_we;
  logic [31:0]       sel_addr, sel_wdata, rd_mux;

  logic              m0_ack_nx, m1_ack_nx, m_err_nx, wem_nx, we1_nx, we2_nx;
  logic [31:0]       m_rdata_nx;

  // last_gnt holds the previously granted master; on contention the other one wins
  assign any_req   = m0_req | m1_req;
  assign win       = (m0_req & m1_req) ? ~last_gnt : m1_req;
  assign sel_addr  = win ? m1_addr  : m0_addr;
  assign sel_we    = win ? m1_we    : m0_we;
  assign sel_wdata = win ? m1_wdata : m0_wdata;

  mips_bus_decode u_decode (
    .page   (sel_addr[31:8]),
    .region (sel_region)
  );

  always_comb begin
    rd_mux = '0;
    case (region)
      REG_MEM: rd_mux = mem_rdata;
      REG_IO1: rd_mux = io1_rdata;
      REG_IO2: rd_mux = io2_rdata;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = (sel_region == REG_NONE) ? RESP : ACCESS;
      ACCESS:  if (cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; ack is raised on entry to RESP
  always_comb begin
    m0_ack_nx  = 1'b0;
    m1_ack_nx  = 1'b0;
    m_err_nx   = 1'b0;
    m_rdata_nx = '0;
    wem_nx     = 1'b0;
    we1_nx     = 1'b0;
    we2_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (sel_region == REG_NONE) begin
            m_err_nx  = 1'b1;
            m0_ack_nx = ~win;
            m1_ack_nx = win;
          end else if (sel_we) begin
            wem_nx = (sel_region == REG_MEM);
            we1_nx = (sel_region == REG_IO1);
            we2_nx = (sel_region == REG_IO2);
          end
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          m0_ack_nx  = ~gnt;
          m1_ack_nx  = gnt;
          m_rdata_nx = we_q ? 32'd0 : rd_mux;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
      wem     <= 1'b0;
      we1     <= 1'b0;
      we2     <= 1'b0;
    end else begin
      m0_ack  <= m0_ack_nx;
      m1_ack  <= m1_ack_nx;
      m_err   <= m_err_nx;
      m_rdata <= m_rdata_nx;
      wem     <= wem_nx;
      we1     <= we1_nx;
      we2     <= we2_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt  <= 1'b1;
      gnt       <= 1'b0;
      we_q      <= 1'b0;
      region    <= REG_NONE;
      cnt       <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        last_gnt  <= win;
        gnt       <= win;
        we_q      <= sel_we;
        region    <= sel_region;
        cnt       <= (sel_region == REG_MEM) ? MEM_CNT : IO_CNT;
        bus_addr  <= sel_addr;
        bus_wdata <= sel_wdata;
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_bus_arb.sv
// tb/tb_mips_bus_arb.sv - directed self-checking bench for mips_bus_arb
module tb_mips_bus_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] mem_rdata, io1_rdata, io2_rdata;

  logic        m0_ack, m1_ack, m_err, wem, we1, we2;
  logic [31:0] m_rdata, bus_addr, bus_wdata;
  logic        w3_m0_ack, w3_m1_ack, w3_m_err, w3_wem, w3_we1, w3_we2;
  logic [31:0] w3_m_rdata, w3_bus_addr, w3_bus_wdata;

  logic [5:0] c1, c3;
  assign c1 = {m0_ack, m1_ack, m_err, wem, we1, we2};
  assign c3 = {w3_m0_ack, w3_m1_ack, w3_m_err, w3_wem, w3_we1, w3_we2};

  int n_cmp = 0;
  int n_bad = 0;

  mips_bus_arb #(.MEM_WAIT(0), .IO_WAIT(1), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .m_err(m_err), .m_rdata(m_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .wem(wem), .we1(we1), .we2(we2),
    .mem_rdata(mem_rdata), .io1_rdata(io1_rdata), .io2_rdata(io2_rdata)
  );

  mips_bus_arb #(.MEM_WAIT(0), .IO_WAIT(3), .WAIT_W(4)) dut_w3 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m0_ack(w3_m0_ack), .m1_ack(w3_m1_ack), .m_err(w3_m_err), .m_rdata(w3_m_rdata),
    .bus_addr(w3_bus_addr), .bus_wdata(w3_bus_wdata), .wem(w3_wem), .we1(w3_we1), .we2(w3_we2),
    .mem_rdata(mem_rdata), .io1_rdata(io1_rdata), .io2_rdata(io2_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  // Drive one request and watch until its ack; n = edges from the IDLE sample (0 on timeout)
  task automatic txn(input bit m, input logic [31:0] a, input logic we, input logic [31:0] wd,
                     output int n, output int stb, output int stb_edge, output logic [2:0] stb_vec,
                     output logic [31:0] ba, output logic [31:0] bwd,
                     output logic [31:0] rd, output logic err);
    n = 0; stb = 0; stb_edge = 0; stb_vec = '0; ba = '0; bwd = '0; rd = '0; err = 1'b0;
    if (m) begin m1_req = 1'b1; m1_addr = a; m1_we = we; m1_wdata = wd; end
    else   begin m0_req = 1'b1; m0_addr = a; m0_we = we; m0_wdata = wd; end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (wem | we1 | we2) begin
        stb++; stb_edge = i; stb_vec = {wem, we1, we2}; ba = bus_addr; bwd = bus_wdata;
      end
      if (m ? m1_ack : m0_ack) begin
        n = i; rd = m_rdata; err = m_err;
        break;
      end
    end
    idle_inputs();
  endtask

  int          n, stb, stb_edge, na;
  logic [2:0]  stb_vec;
  logic [31:0] ba, bwd, rd;
  logic        err;
  int          ack_edge[4];
  logic        ack_who[4];

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    mem_rdata = '0; io1_rdata = '0; io2_rdata = '0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      m0_req = 1'($urandom); m0_we = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
      m1_req = 1'($urandom); m1_we = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
      mem_rdata = $urandom; io1_rdata = $urandom; io2_rdata = $urandom;
      tick();
      chk("rst_ctl", {26'd0, c1}, 32'd0);
      chk("rst_data", m_rdata | bus_addr | bus_wdata, 32'd0);
      chk("rst_w3", {26'd0, c3} | w3_m_rdata | w3_bus_addr | w3_bus_wdata, 32'd0);
    end
    idle_inputs();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("noreq_ctl", {26'd0, c1}, 32'd0);
      chk("noreq_data", m_rdata | bus_addr | bus_wdata, 32'd0);
    end

    // RAM write by m0, MEM_WAIT=0
    mem_rdata = 32'h11111111; io1_rdata = 32'h0000005A; io2_rdata = 32'h22222222;
    txn(1'b0, 32'h00000010, 1'b1, 32'hDEADBEEF, n, stb, stb_edge, stb_vec, ba, bwd, rd, err);
    chk("wr_latency", n, 2);
    chk("wr_stb_count", stb, 1);
    chk("wr_stb_edge", stb_edge, 1);
    chk("wr_stb_which", {29'd0, stb_vec}, 32'd4);
    chk("wr_bus_addr", ba, 32'h00000010);
    chk("wr_bus_wdata", bwd, 32'hDEADBEEF);
    chk("wr_err", {31'd0, err}, 32'd0);
    chk("wr_rdata", rd, 32'd0);
    tick();
    chk("wr_after_ctl", {26'd0, c1}, 32'd0);

    // IO1 read by m1, IO_WAIT=1
    txn(1'b1, 32'h00000804, 1'b0, 32'hFFFFFFFF, n, stb, stb_edge, stb_vec, ba, bwd, rd, err);
    chk("io1_latency", n, 3);
    chk("io1_stb_count", stb, 0);
    chk("io1_rdata", rd, 32'h0000005A);
    chk("io1_err", {31'd0, err}, 32'd0);
    chk("io1_bus_addr", bus_addr, 32'h00000804);
    tick();
    chk("io1_after", {26'd0, c1} | m_rdata, 32'd0);

    // unmapped write by m0
    txn(1'b0, 32'h00001000, 1'b1, 32'h12345678, n, stb, stb_edge, stb_vec, ba, bwd, rd, err);
    chk("unm_latency", n, 1);
    chk("unm_stb_count", stb, 0);
    chk("unm_err", {31'd0, err}, 32'd1);
    chk("unm_rdata", rd, 32'd0);
    tick();
    chk("unm_after", {26'd0, c1} | m_rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("unm_no_stb", {29'd0, wem, we1, we2}, 32'd0);
    end

    // contention from reset: both masters continuously reading RAM
    rst_n = 1'b0;
    tick(); tick();
    mem_rdata = 32'hCAFE0001;
    m0_req = 1'b1; m0_addr = 32'h00000020; m0_we = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h00000040; m1_we = 1'b0;
    rst_n = 1'b1;
    na = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("dual_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
      if (m0_ack | m1_ack) begin
        if (na < 4) begin ack_edge[na] = i; ack_who[na] = m1_ack; end
        if (na == 0) chk("cont_rdata", m_rdata, 32'hCAFE0001);
        na++;
      end
    end
    chk("cont_ack_count", na, 4);
    for (int k = 0; k < 4 && k < na; k++) begin
      chk($sformatf("cont_who%0d", k), {31'd0, ack_who[k]}, k % 2);
      chk($sformatf("cont_edge%0d", k), ack_edge[k], 2 + 3 * k);
    end
    idle_inputs();

    // reset during the second ACCESS cycle of an IO2 read (IO_WAIT=3)
    rst_n = 1'b0;
    tick();
    io2_rdata = 32'hA5A5A5A5;
    m0_req = 1'b1; m0_addr = 32'h000009C4; m0_we = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("abort_ack1", {31'd0, w3_m0_ack}, 32'd0);
    chk("abort_bus_addr", w3_bus_addr, 32'h000009C4);
    tick();
    chk("abort_ack2", {31'd0, w3_m0_ack}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_ctl", {26'd0, c3}, 32'd0);
    chk("abort_data", w3_m_rdata | w3_bus_addr | w3_bus_wdata, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (w3_m0_ack) begin
        n = i; rd = w3_m_rdata; err = w3_m_err;
        break;
      end
    end
    chk("restart_latency", n, 5);
    chk("restart_rdata", rd, 32'hA5A5A5A5);
    chk("restart_err", {31'd0, err}, 32'd0);
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
